// File: rtl/rs232in_fifo.sv
// Receive-side byte FIFO between the rs232in deserializer and the rs232 register block.
// Bytes announced by in_attention are queued; rd_strobe pops one byte into a registered rd_data.
module rs232in_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int WIDTH      = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_attention,
    input  logic [WIDTH-1:0]      in_data,
    input  logic                  rd_strobe,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  rd_valid,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  empty,
    output logic                  full,
    output logic                  overflow,
    input  logic                  clr_overflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
    logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic [WIDTH-1:0]      rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  overflow_q, overflow_d;
    logic                  empty_w, full_w;
    logic                  pop_ok, push_ok, drop;

    assign empty_w = (count_q == '0);
    assign full_w  = (count_q == DEPTH_CNT);

    // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
    assign pop_ok  = rd_strobe && !empty_w;
    assign push_ok = in_attention && (!full_w || pop_ok);
    assign drop    = in_attention && !push_ok;

    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = pop_ok;
        overflow_d = overflow_q;
        count_d    = count_q + {{DEPTH_LOG2{1'b0}}, push_ok} - {{DEPTH_LOG2{1'b0}}, pop_ok};

        if (push_ok) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (pop_ok) begin
            rptr_d    = rptr_q + 1'b1;
            rd_data_d = mem_q[rptr_q];
        end
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: contents are only visible through the pointers.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wptr_q] <= in_data;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign count    = count_q;
    assign empty    = empty_w;
    assign full     = full_w;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_rs232in_fifo.sv
// Self-checking bench for rs232in_fifo (depth 4) against a queue-based reference model.
module tb_rs232in_fifo;

    localparam int DL2   = 2;
    localparam int DEPTH = 1 << DL2;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           in_attention = 1'b0;
    logic [7:0]     in_data = 8'h00;
    logic           rd_strobe = 1'b0;
    logic [7:0]     rd_data;
    logic           rd_valid;
    logic [DL2:0]   count;
    logic           empty;
    logic           full;
    logic           overflow;
    logic           clr_overflow = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] q[$];
    logic [7:0] exp_data = 8'h00;
    logic       exp_valid = 1'b0;
    logic       exp_ovf = 1'b0;

    rs232in_fifo #(.DEPTH_LOG2(DL2), .WIDTH(8)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_attention (in_attention),
        .in_data      (in_data),
        .rd_strobe    (rd_strobe),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .count        (count),
        .empty        (empty),
        .full         (full),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    always #5 clk = ~clk;

    // One clock of stimulus; model is updated from the pre-edge state, outputs settle by posedge+1.
    task automatic step(input logic att, input logic [7:0] d, input logic rd, input logic clr);
        logic pop, push;
        @(negedge clk);
        in_attention = att;
        in_data      = d;
        rd_strobe    = rd;
        clr_overflow = clr;
        @(posedge clk);
        pop  = rd && (q.size() > 0);
        push = att && ((q.size() < DEPTH) || pop);
        exp_valid = pop;
        if (pop) exp_data = q.pop_front();
        if (push) q.push_back(d);
        if (att && !push) exp_ovf = 1'b1;
        else if (clr) exp_ovf = 1'b0;
        #1;
        in_attention = 1'b0;
        rd_strobe    = 1'b0;
        clr_overflow = 1'b0;
    endtask

    task automatic model_reset();
        q.delete();
        exp_data  = 8'h00;
        exp_valid = 1'b0;
        exp_ovf   = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        step(1'b0, 8'h00, 1'b0, 1'b0);
        n_checks++;
        if (count !== 3'd0 || empty !== 1'b1 || full !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_status: count=%0d empty=%b full=%b, required count=0 empty=1 full=0", count, empty, full);
        end
        n_checks++;
        if (rd_valid !== 1'b0 || overflow !== 1'b0 || rd_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_outputs: rd_valid=%b overflow=%b rd_data=%h, required 0 0 00", rd_valid, overflow, rd_data);
        end
    endtask

    task automatic test_basic();
        logic [7:0] vals [3];
        vals[0] = 8'h41; vals[1] = 8'h42; vals[2] = 8'h43;
        for (int i = 0; i < 3; i++) step(1'b1, vals[i], 1'b0, 1'b0);
        n_checks++;
        if (count !== 3'd3) begin
            n_fail++;
            $display("FAIL basic_fill_count: count=%0d, required 3", count);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            n_checks++;
            if (rd_valid !== 1'b1 || rd_data !== vals[i] || count !== 3'(2 - i)) begin
                n_fail++;
                $display("FAIL basic_pop%0d: rd_valid=%b rd_data=%h count=%0d, required 1 %h %0d",
                         i, rd_valid, rd_data, count, vals[i], 2 - i);
            end
        end
        step(1'b0, 8'h00, 1'b0, 1'b0);
        n_checks++;
        if (rd_valid !== 1'b0 || empty !== 1'b1 || rd_data !== 8'h43) begin
            n_fail++;
            $display("FAIL basic_end: rd_valid=%b empty=%b rd_data=%h, required 0 1 43", rd_valid, empty, rd_data);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 4; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        n_checks++;
        if (full !== 1'b1 || count !== 3'd4 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_full: full=%b count=%0d overflow=%b, required 1 4 0", full, count, overflow);
        end
        step(1'b1, 8'h04, 1'b0, 1'b0);
        n_checks++;
        if (overflow !== 1'b1 || count !== 3'd4) begin
            n_fail++;
            $display("FAIL ovf_drop: overflow=%b count=%0d, required 1 4", overflow, count);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            n_checks++;
            if (rd_valid !== 1'b1 || rd_data !== 8'(i)) begin
                n_fail++;
                $display("FAIL ovf_drain%0d: rd_valid=%b rd_data=%h, required 1 %h", i, rd_valid, rd_data, 8'(i));
            end
        end
        n_checks++;
        if (overflow !== 1'b1 || empty !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_sticky: overflow=%b empty=%b, required 1 1", overflow, empty);
        end
        step(1'b0, 8'h00, 1'b0, 1'b1);
        n_checks++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clear: overflow=%b, required 0", overflow);
        end
    endtask

    task automatic test_full_simul();
        for (int i = 0; i < 4; i++) step(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
        step(1'b1, 8'h55, 1'b1, 1'b0);
        n_checks++;
        if (overflow !== 1'b0 || count !== 3'd4 || rd_data !== 8'hA0 || rd_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL full_simul: overflow=%b count=%0d rd_data=%h rd_valid=%b, required 0 4 a0 1",
                     overflow, count, rd_data, rd_valid);
        end
        for (int i = 0; i < 4; i++) begin
            logic [7:0] e;
            e = (i < 3) ? 8'hA1 + 8'(i) : 8'h55;
            step(1'b0, 8'h00, 1'b1, 1'b0);
            n_checks++;
            if (rd_valid !== 1'b1 || rd_data !== e) begin
                n_fail++;
                $display("FAIL full_simul_drain%0d: rd_valid=%b rd_data=%h, required 1 %h", i, rd_valid, rd_data, e);
            end
        end
    endtask

    task automatic test_wrap();
        int sent = 0;
        int recv = 0;
        int cyc  = 0;
        int max_cnt = 0;
        while (recv < 37 && cyc < 400) begin
            logic att, rd;
            att = (sent < 37) && (q.size() < 3) && ($urandom_range(0, 2) != 0);
            rd  = (sent == 37) || ($urandom_range(0, 1) == 1);
            step(att, 8'(sent), rd, 1'b0);
            if (att) sent++;
            if (int'(count) > max_cnt) max_cnt = int'(count);
            if (rd_valid === 1'b1) begin
                n_checks++;
                if (rd_data !== 8'(recv)) begin
                    n_fail++;
                    $display("FAIL wrap_order: rd_data=%h, required %h", rd_data, 8'(recv));
                end
                recv++;
            end
            cyc++;
        end
        n_checks++;
        if (recv != 37) begin
            n_fail++;
            $display("FAIL wrap_timeout: received %0d bytes, required 37", recv);
        end
        n_checks++;
        if (max_cnt > 3) begin
            n_fail++;
            $display("FAIL wrap_maxcount: count reached %0d, required <= 3", max_cnt);
        end
    endtask

    task automatic test_empty_simul();
        step(1'b1, 8'h7E, 1'b1, 1'b0);
        n_checks++;
        if (rd_valid !== 1'b0 || count !== 3'd1) begin
            n_fail++;
            $display("FAIL empty_simul: rd_valid=%b count=%0d, required 0 1", rd_valid, count);
        end
        step(1'b0, 8'h00, 1'b1, 1'b0);
        n_checks++;
        if (rd_valid !== 1'b1 || rd_data !== 8'h7E) begin
            n_fail++;
            $display("FAIL empty_simul_pop: rd_valid=%b rd_data=%h, required 1 7e", rd_valid, rd_data);
        end
    endtask

    task automatic test_async_reset();
        step(1'b1, 8'h11, 1'b0, 1'b0);
        step(1'b1, 8'h22, 1'b0, 1'b0);
        n_checks++;
        if (count !== 3'd2) begin
            n_fail++;
            $display("FAIL areset_pre: count=%0d, required 2", count);
        end
        #1;
        reset_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (count !== 3'd0 || empty !== 1'b1 || rd_data !== 8'h00) begin
            n_fail++;
            $display("FAIL areset_async: count=%0d empty=%b rd_data=%h, required 0 1 00", count, empty, rd_data);
        end
        @(negedge clk);
        reset_n = 1'b1;
        step(1'b0, 8'h00, 1'b1, 1'b0);
        n_checks++;
        if (rd_valid !== 1'b0 || count !== 3'd0) begin
            n_fail++;
            $display("FAIL areset_discard: rd_valid=%b count=%0d, required 0 0", rd_valid, count);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            logic att, rd, clr;
            att = ($urandom_range(0, 99) < 55);
            rd  = ($urandom_range(0, 99) < 45);
            clr = ($urandom_range(0, 99) < 8);
            step(att, 8'($urandom), rd, clr);
            n_checks++;
            if (count !== 3'(q.size()) || empty !== (q.size() == 0) || full !== (q.size() == DEPTH) ||
                rd_valid !== exp_valid || rd_data !== exp_data || overflow !== exp_ovf) begin
                n_fail++;
                $display("FAIL random_cyc%0d: count=%0d empty=%b full=%b rd_valid=%b rd_data=%h overflow=%b, required %0d %b %b %b %h %b",
                         i, count, empty, full, rd_valid, rd_data, overflow,
                         q.size(), q.size() == 0, q.size() == DEPTH, exp_valid, exp_data, exp_ovf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_full_simul();
        test_wrap();
        while (q.size() > 0) step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        test_empty_simul();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rs232in_fifo.md
Name: rs232in_fifo

Overview:
- Receive-side byte buffer between the rs232in deserializer and the rs232 peripheral register block.
- Captures each byte that rs232in announces with its one-cycle attention pulse and queues it in a circular FIFO, so CPU polling latency no longer loses characters at 115200 baud.
- The rs232 peripheral pops bytes with a read strobe and reports the FIFO count and a sticky overflow flag to software.

Parameters:
DEPTH_LOG2, 4, log2 of FIFO depth (default depth 16 bytes)
WIDTH, 8, data width in bits

Ports:
clk  input  1  system clock (same clock as rs232in and rs232)
reset_n  input  1  asynchronous active-low reset
in_attention  input  1  one-cycle pulse from rs232in: in_data is valid this cycle
in_data  input  WIDTH  received byte from rs232in
rd_strobe  input  1  pop request from rs232 peripheral
rd_data  output  WIDTH  popped byte, registered
rd_valid  output  1  one-cycle pulse: rd_data updated this cycle
count  output  DEPTH_LOG2+1  number of bytes currently stored (0..2^DEPTH_LOG2)
empty  output  1  count == 0
full  output  1  count == 2^DEPTH_LOG2
overflow  output  1  sticky: a byte was dropped because the FIFO was full
clr_overflow  input  1  clears overflow; set takes priority when both occur in the same cycle

Behaviour:
- Reset (reset_n low, asynchronous):
  - Write/read pointers and count go to 0; empty=1, full=0.
  - rd_data=0, rd_valid=0, overflow=0.
  - Storage contents are don't-care.
  - Reset asserted mid-operation discards all queued bytes immediately.
- Storage: 2^DEPTH_LOG2 x WIDTH array; pointers are DEPTH_LOG2 bits and wrap naturally modulo depth.
- Write (push): on a rising clk edge with in_attention=1:
  - If not full, or if a pop occurs in the same cycle: mem[wptr]<=in_data, wptr<=wptr+1.
  - If full and no pop: byte is dropped, overflow<=1, pointers and count unchanged.
- Read (pop): on a rising clk edge with rd_strobe=1 and empty=0:
  - rd_data<=mem[rptr], rptr<=rptr+1, rd_valid<=1 on the following cycle.
  - Latency: strobe in cycle N gives rd_data/rd_valid in cycle N+1.
  - rd_valid is 0 in every other cycle.
- rd_strobe while empty: ignored; rd_valid stays 0 and rd_data holds its previous value. No bypass: a byte written in the same cycle is not returned by that strobe.
- Simultaneous push and pop:
  - Not empty: both occur and count is unchanged.
  - Full: push is accepted, no overflow.
  - Empty: only the push occurs and count becomes 1.
- count arithmetic:
  - count <= count + push_ok - pop_ok.
  - DEPTH_LOG2+1 bits, so full is representable; never exceeds 2^DEPTH_LOG2 and never underflows.
- empty and full are derived combinationally from the registered count (glitch-free in the clk domain).
- Back-to-back strobes every cycle drain one byte per cycle; rd_valid stays high continuously while data remains.
- overflow is cleared only by clr_overflow or reset. Drops keep occurring while full, but overflow carries no drop count.
- No combinational path from in_* or rd_strobe to any output except through registers (count, empty and full are registered/derived).

Test Plan:
- Reset then idle -> count=0, empty=1, full=0, rd_valid=0, overflow=0, rd_data=0.
- Push 0x41,0x42,0x43 on separate cycles, then rd_strobe three consecutive cycles -> rd_valid high three cycles starting one cycle after the first strobe; rd_data 0x41,0x42,0x43; count 3->2->1->0; empty=1 at end.
- With DEPTH_LOG2=2:
  - Push 0x00..0x04 -> full=1 after the 4th byte; 5th byte 0x04 dropped, overflow=1, count=4.
  - Drain -> 0x00..0x03.
  - clr_overflow -> overflow=0.
- Full FIFO (DEPTH_LOG2=2), same-cycle in_attention=1 (0x55) and rd_strobe=1 -> no overflow, count stays 4; draining returns the old 3 bytes then 0x55.
- Wrap-around: push/pop 37 bytes 0x00..0x24 interleaved with up to 3 outstanding -> output sequence identical to input and count never exceeds 3.
- Empty FIFO, rd_strobe=1 together with in_attention=1 (0x7E) -> rd_valid=0 next cycle, count=1; next strobe returns 0x7E. Asserting reset_n=0 mid-stream with 2 bytes queued -> count=0 asynchronously, before the next clk edge.
